// File: rtl/fp_recip_result_stage.sv
// Two-entry valid/ready output buffer for the FP reciprocal unit, with sticky
// exception flags and a saturating delivered-result counter.
module fp_recip_result_stage #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_z,
  input  logic [7:0]                     in_status,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   out_z,
  output logic [7:0]                     out_status,
  input  logic                           flags_clr,
  output logic [7:0]                     sticky_flags,
  output logic [CNT_WIDTH-1:0]           result_cnt
);

  localparam int ZW = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int EW = ZW + 8;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                state_q, state_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [EW-1:0]         mem_q [2];
  logic [EW-1:0]         mem_d [2];
  logic [7:0]            sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  push, pop;
  logic [EW-1:0]         head;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Handshake decoded from the state register alone; no out_ready->in_ready path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is not reset, so the head is forced to zero while empty.
  assign head         = out_valid ? mem_q[rd_q] : '0;
  assign out_z        = head[ZW-1:0];
  assign out_status   = head[EW-1:ZW];
  assign sticky_flags = sticky_q;
  assign result_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    rd_d = rd_q ^ pop;
    wr_d = wr_q ^ push;

    mem_d = mem_q;
    if (push) mem_d[wr_q] = {in_status, in_z};

    sticky_d = (flags_clr ? 8'h00 : sticky_q) | (push ? in_status : 8'h00);
    cnt_d    = pop ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      sticky_q <= 8'h00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fp_recip_result_stage.sv
// Directed bench for fp_recip_result_stage; a second instance with a 2-bit
// counter exercises counter saturation on the same stimulus.
module tb_fp_recip_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic        flags_clr;
  logic [7:0]  sticky_flags;
  logic [15:0] result_cnt;

  logic        in_ready2, out_valid2;
  logic [31:0] out_z2;
  logic [7:0]  out_status2, sticky_flags2;
  logic [1:0]  result_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_recip_result_stage #(.SIG_WIDTH(23), .EXP_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_status(in_status), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags), .result_cnt(result_cnt)
  );

  fp_recip_result_stage #(.SIG_WIDTH(23), .EXP_WIDTH(8), .CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_z(in_z), .in_status(in_status), .out_valid(out_valid2),
    .out_ready(out_ready), .out_z(out_z2), .out_status(out_status2),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags2), .result_cnt(result_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] z, input logic [7:0] st);
    in_valid  = v;
    in_z      = z;
    in_status = st;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; flags_clr = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_status", out_status, 0);
    chk("rst_sticky", sticky_flags, 0);
    chk("rst_cnt", result_cnt, 0);

    // Single word, consumer ready: one cycle latency, then popped.
    out_ready = 1'b1;
    drive(1'b1, 32'h3E800000, 8'h00);
    step();
    drive(1'b0, 32'h0, 8'h00);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_z", out_z, 32'h3E800000);
    step();
    chk("t1_empty", out_valid, 0);
    chk("t1_cnt", result_cnt, 1);

    // Fill with consumer stalled; a third word must be refused.
    out_ready = 1'b0;
    drive(1'b1, 32'h3F000000, 8'h00); step();
    drive(1'b1, 32'h40000000, 8'h00); step();
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_head_a", out_z, 32'h3F000000);
    drive(1'b1, 32'h41000000, 8'h00); step();
    drive(1'b0, 32'h0, 8'h00);
    chk("t2_head_hold", out_z, 32'h3F000000);
    chk("t2_still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("t2_head_b", out_z, 32'h40000000);
    step();
    chk("t2_drained", out_valid, 0);
    chk("t2_cnt", result_cnt, 3);

    // FULL with push and pop offered together: only the pop happens.
    out_ready = 1'b0;
    drive(1'b1, 32'h3F800000, 8'h00); step();
    drive(1'b1, 32'h40400000, 8'h00); step();
    drive(1'b1, 32'h40800000, 8'h00);
    out_ready = 1'b1;
    step();
    chk("t3_in_ready", in_ready, 1);
    chk("t3_head_e", out_z, 32'h40400000);
    out_ready = 1'b0;
    step();
    drive(1'b0, 32'h0, 8'h00);
    chk("t3_full_again", in_ready, 0);
    chk("t3_head_e_hold", out_z, 32'h40400000);
    out_ready = 1'b1;
    step();
    chk("t3_head_f", out_z, 32'h40800000);
    step();
    chk("t3_no_dup", out_valid, 0);
    chk("t3_cnt", result_cnt, 6);

    // Sticky flags accumulate; a clear with a push keeps only the new status.
    drive(1'b1, 32'h7F800000, 8'h82); step();
    drive(1'b1, 32'h00800000, 8'h28); step();
    chk("t4_sticky_or", sticky_flags, 8'hAA);
    chk("t4_status_pass", out_status, 8'h28);
    drive(1'b1, 32'h3F000000, 8'h20);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
    chk("t4_clr_push", sticky_flags, 8'h20);
    step();
    chk("t4_cnt", result_cnt, 9);
    flags_clr = 1'b1; step(); flags_clr = 1'b0;
    chk("t4_clr_only", sticky_flags, 8'h00);

    // Counter saturation on the 2-bit instance.
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_cnt2", result_cnt2, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3F800000 + i, 8'h00);
      step();
    end
    drive(1'b0, 32'h0, 8'h00);
    step();
    chk("t5_cnt16", result_cnt, 5);
    chk("t5_cnt2_sat", result_cnt2, 3);
    drive(1'b1, 32'h3F800000, 8'h00); step();
    drive(1'b0, 32'h0, 8'h00); step();
    chk("t5_cnt2_hold", result_cnt2, 3);

    // Reset while FULL discards everything.
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 8'h01); step();
    drive(1'b1, 32'h22222222, 8'h04); step();
    chk("t6_full", in_ready, 0);
    rst = 1'b1; out_ready = 1'b1; flags_clr = 1'b0;
    drive(1'b1, 32'h33333333, 8'h10);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_sticky", sticky_flags, 0);
    chk("t6_cnt", result_cnt, 0);
    chk("t6_out_z", out_z, 0);
    step(); step();
    chk("t6_stays_empty", out_valid, 0);
    chk("t6_cnt_hold", result_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
